uart_tx_mmio: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_mmio.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   Register offsets (address[3:2]), transmitter FSM state encoding and
//   the number of data bits per frame.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
//   clk, rst       : clock, synchronous active-high reset (flushes the FIFO)
//   push, din      : enqueue din; ignored while full, even if a pop happens
//                    in the same cycle
//   pop, dout      : dequeue; dout always shows the head entry
//   full, empty    : derived from the count at the start of the cycle
//   count          : number of stored entries
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [7:0]                  din,
  output logic [7:0]                  dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter (8N1, LSB first) on the store bus.
//   clk, rst   : clock, synchronous active-high reset
//   address    : byte address; window is BASE_ADDR[31:4], address[3:2] = reg
//   wd, we     : write data / write enable (data taken from the low lanes)
//   mem_ctrl   : access size, not used for decode
//   rd         : combinational read data (0 when not selected)
//   tx         : serial line, idles high
// Registers: 0 DATA (write pushes a byte), 1 STATUS {ovf, full, busy},
//            2 DIV (clk cycles per bit, 0 stored as 1), 3 reserved.
// Build option UART_TX_PARITY_EN: adds an even-parity bit after the data
// bits and reports it in STATUS bit 3.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); chains straight into START if more data queued
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h00400010,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [1:0]  mem_ctrl,
  output logic [31:0] rd,
  output logic        tx
);
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  tx_state_t state, state_n;

  logic                        sel;
  logic [1:0]                  reg_idx;
  logic                        wr_data, wr_status, wr_div;
  logic                        ovf;
  logic [15:0]                 div;
  logic [15:0]                 div_active;
  logic [15:0]                 baud_cnt;
  logic [2:0]                  bit_cnt;
  logic [7:0]                  shift;
  logic                        baud_done;
  logic                        load;
  logic                        fifo_pop;
  logic [7:0]                  fifo_dout;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        busy;
  logic                        unused_bits;

  assign unused_bits = ^{mem_ctrl, address[1:0], wd[31:16], fifo_count};

  assign sel       = (address[31:4] == BASE_ADDR[31:4]);
  assign reg_idx   = address[3:2];
  assign wr_data   = we && sel && (reg_idx == REG_DATA);
  assign wr_status = we && sel && (reg_idx == REG_STATUS);
  assign wr_div    = we && sel && (reg_idx == REG_DIV);

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy      = (state != IDLE) || !fifo_empty;
  assign baud_done = (baud_cnt == div_active - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
    end else begin
      // A push onto a full FIFO is lost even if the FSM pops that cycle.
      if (wr_data && fifo_full) ovf <= 1'b1;
      else if (wr_status)       ovf <= 1'b0;
      if (wr_div) div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          state_n  = START;
        end
      end
      START: if (baud_done) state_n = DATA;
      DATA: begin
        if (baud_done && (bit_cnt == 3'(DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_done) state_n = STOP;
`endif
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  always_ff @(posedge clk) begin
    if (rst)       parity_bit <= 1'b0;
    else if (load) parity_bit <= ^fifo_dout;
  end
`endif

  // tx is registered from the current state, so the line trails the FSM by
  // one cycle uniformly; every bit still lasts exactly div_active cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      div_active <= DEFAULT_DIV;
      tx         <= 1'b1;
    end else begin
      if (load || state == IDLE || baud_done) baud_cnt <= '0;
      else                                    baud_cnt <= baud_cnt + 16'd1;

      if (load)                              bit_cnt <= '0;
      else if (state == DATA && baud_done)   bit_cnt <= bit_cnt + 3'd1;

      if (load) begin
        shift      <= fifo_dout;
        div_active <= div;
      end else if (state == DATA && baud_done) begin
        shift <= {1'b0, shift[7:1]};
      end

      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx <= parity_bit;
`endif
        default: tx <= 1'b1;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      case (reg_idx)
        REG_STATUS: rd = {28'b0, PARITY_PRESENT, ovf, fifo_full, busy};
        REG_DIV:    rd = {16'b0, div};
        default:    rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'h00400010;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_DIV  = BASE + 32'd8;
  localparam logic [31:0] A_RSV  = BASE + 32'd12;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam logic [31:0] ST_IDLE = 32'(PAR) << 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wd, rd;
  logic        we;
  logic [1:0]  mem_ctrl;
  logic        tx;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .wd       (wd),
    .we       (we),
    .mem_ctrl (mem_ctrl),
    .rd       (rd),
    .tx       (tx)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    address  = addr;
    wd       = data;
    we       = 1'b1;
    mem_ctrl = 2'b10;
    @(posedge clk);
    #1;
    we      = 1'b0;
    address = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] val);
    address = addr;
    we      = 1'b0;
    #1;
    val     = rd;
    address = 32'h0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Expected line level for bit slot k of a frame carrying b.
  function automatic logic frame_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Cycle-exact comparison of one full frame starting at the next edge.
  task automatic expect_wave(input logic [7:0] b, input int div, output int err,
                             output logic [31:0] mid_status);
    err = 0;
    mid_status = '0;
    for (int k = 0; k < (10 + PAR) * div; k++) begin
      cycles(1);
      if (tx !== frame_level(b, k / div)) err++;
      if (k == 5 * div) bus_read(A_STAT, mid_status);
    end
  endtask

  // Line receiver: finds the start edge, samples every bit at its midpoint.
  task automatic rx_frame(input int div, output logic [7:0] data, output int t0, output int err);
    int w;
    err = 0;
    data = '0;
    t0 = -1;
    w = 0;
    do begin
      cycles(1);
      w++;
    end while (tx !== 1'b0 && w < 3000);
    if (tx !== 1'b0) begin
      err = 100;
      return;
    end
    t0 = cyc;
    cycles(div / 2);
    if (tx !== 1'b0) err++;
    for (int i = 0; i < 8; i++) begin
      cycles(div);
      data[i] = tx;
    end
    if (PAR == 1) begin
      cycles(div);
      if (tx !== ^data) err++;
    end
    cycles(div);
    if (tx !== 1'b1) err++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[14];
    logic [31:0] v, ms;
    logic [7:0]  bytes[6];
    logic [7:0]  got;
    int          err, ta, tb0, low_seen, div, n;

    address = '0; wd = '0; we = 1'b0; mem_ctrl = 2'b00; rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Register map vectors.
    tbl[0]  = '{1'b0, A_STAT, 32'h0, ST_IDLE};
    tbl[1]  = '{1'b0, A_DIV, 32'h0, 32'd434};
    tbl[2]  = '{1'b0, A_DATA, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, A_RSV, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, A_DIV, 32'h4, 32'h0};
    tbl[5]  = '{1'b0, A_DIV, 32'h0, 32'h4};
    tbl[6]  = '{1'b1, A_DIV, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, A_DIV, 32'h0, 32'h1};
    tbl[8]  = '{1'b1, A_DIV, 32'hABCD1234, 32'h0};
    tbl[9]  = '{1'b0, A_DIV, 32'h0, 32'h1234};
    tbl[10] = '{1'b1, A_RSV, 32'hFFFFFFFF, 32'h0};
    tbl[11] = '{1'b0, A_RSV, 32'h0, 32'h0};
    tbl[12] = '{1'b0, BASE + 32'h18, 32'h0, 32'h0};
    tbl[13] = '{1'b0, 32'h00000018, 32'h0, 32'h0};
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].wdata);
      end else begin
        bus_read(tbl[i].addr, v);
        check($sformatf("reg_vec%0d", i), v, tbl[i].exp);
      end
    end

    // Single frame, latency and exact waveform.
    bus_write(A_DIV, 32'd4);
    bus_write(A_DATA, 32'h55);
    cycles(1);
    check("latency_still_high", {31'b0, tx}, 32'd1);
    expect_wave(8'h55, 4, err, ms);
    check("wave_55", err, 0);
    check("busy_mid_frame", ms, ST_IDLE | 32'd1);
    bus_read(A_STAT, v);
    check("idle_after_55", v, ST_IDLE);

    // Two back-to-back frames.
    bus_write(A_DIV, 32'd2);
    bus_write(A_DATA, 32'hA3);
    bus_write(A_DATA, 32'h0F);
    expect_wave(8'hA3, 2, err, ms);
    check("wave_A3", err, 0);
    expect_wave(8'h0F, 2, err, ms);
    check("wave_0F_no_gap", err, 0);
    cycles(1);
    check("idle_line_after_pair", {31'b0, tx}, 32'd1);

    // Overflow: six writes into a 4-deep FIFO.
    bus_write(A_DIV, 32'd8);
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 6; i++) bus_write(A_DATA, {24'h0, bytes[i]});
        bus_read(A_STAT, v);
        check("ovf_full_busy", v, ST_IDLE | 32'd7);
        bus_write(A_STAT, 32'h0);
        bus_read(A_STAT, v);
        check("ovf_cleared", v, ST_IDLE | 32'd3);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_frame(8, got, ta, err);
          check($sformatf("ovf_rx_err%0d", i), err, 0);
          check($sformatf("ovf_rx_byte%0d", i), {24'h0, got}, {24'h0, bytes[i]});
        end
      end
    join
    low_seen = 0;
    for (int i = 0; i < 200; i++) begin
      cycles(1);
      if (tx === 1'b0) low_seen++;
    end
    check("no_sixth_frame", low_seen, 0);

    // Divisor change mid-frame applies only to the next frame.
    bus_write(A_DIV, 32'd4);
    fork
      begin
        bus_write(A_DATA, 32'hC6);
        bus_write(A_DATA, 32'h39);
        repeat (10) @(posedge clk);
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, v);
        check("div_zero_is_one", v, 32'd1);
        bus_write(A_DIV, 32'd2);
      end
      begin
        rx_frame(4, got, ta, err);
        check("divchg_f1_err", err, 0);
        check("divchg_f1_byte", {24'h0, got}, 32'hC6);
        rx_frame(2, got, tb0, err);
        check("divchg_f2_err", err, 0);
        check("divchg_f2_byte", {24'h0, got}, 32'h39);
        check("divchg_spacing", tb0 - ta, (10 + PAR) * 4);
      end
    join
    cycles(40);

    // Randomized frames against the receiver model.
    for (int it = 0; it < 6; it++) begin
      div = $urandom_range(6, 1);
      n   = $urandom_range(5, 1);
      for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
      bus_write(A_DIV, 32'(div));
      fork
        begin
          for (int i = 0; i < n; i++) bus_write(A_DATA, {24'h0, bytes[i]});
        end
        begin
          for (int i = 0; i < n; i++) begin
            rx_frame(div, got, tb0, err);
            check($sformatf("rnd%0d_err%0d", it, i), err, 0);
            check($sformatf("rnd%0d_byte%0d", it, i), {24'h0, got}, {24'h0, bytes[i]});
            if (i > 0) check($sformatf("rnd%0d_spacing%0d", it, i), tb0 - ta, (10 + PAR) * div);
            ta = tb0;
          end
        end
      join
      cycles(2 * div + 2);
      bus_read(A_STAT, v);
      check($sformatf("rnd%0d_idle", it), v, ST_IDLE);
    end

`ifdef UART_TX_PARITY_EN
    bus_write(A_DIV, 32'd2);
    bus_write(A_DATA, 32'h07);
    bus_write(A_DATA, 32'h07);
    expect_wave(8'h07, 2, err, ms);
    check("parity_wave1", err, 0);
    expect_wave(8'h07, 2, err, ms);
    check("parity_wave2_22cyc", err, 0);
    bus_read(A_STAT, v);
    check("parity_status_bit3", v & 32'h8, 32'h8);
`endif

    // Reset in the middle of the data bits.
    bus_write(A_DIV, 32'd4);
    bus_write(A_DATA, 32'h00);
    bus_write(A_DATA, 32'h00);
    bus_write(A_DATA, 32'h00);
    repeat (14) @(posedge clk);
    #2;
    check("pre_reset_tx_low", {31'b0, tx}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("reset_tx_high", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, v);
    check("reset_status", v, ST_IDLE);
    bus_read(A_DIV, v);
    check("reset_div", v, 32'd434);
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      cycles(1);
      if (tx === 1'b0) low_seen++;
    end
    check("reset_fifo_flushed", low_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
